// File: rtl/wb_line_memory_if.sv
// Wishbone line-bus bundle between the cache memory-side master and wb_line_memory.
// Latency: none, wires only.
// Backpressure: none of its own; the responder paces the master with ack/rty.
interface wb_line_memory_if;
  logic         cyc;
  logic         stb;
  logic         we;
  logic [11:0]  adr;
  logic [15:0]  sel;
  logic [127:0] dat_m;
  logic [127:0] dat_s;
  logic         ack;
  logic         rty;

  modport master (
    output cyc, stb, we, adr, sel, dat_m,
    input  dat_s, ack, rty
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_m,
    output dat_s, ack, rty
  );
endinterface

// File: rtl/wb_line_memory.sv
// Line-granular Wishbone memory: 128-bit line reads and byte-masked line writes.
// Latency: ack in cycle LATENCY after the request is sampled, one cycle wide.
// Backpressure: single outstanding request; a request held across ack waits in HOLD
// until the strobe drops. Optional first-touch retry is built when
// WB_LINE_MEM_RETRY_EN is defined; otherwise rty is tied low.
module wb_line_memory #(
  parameter int DEPTH_LINES = 256,
  parameter int LATENCY     = 4
) (
  input  logic            clk,
  input  logic            rst,
  wb_line_memory_if.slave wb
);

  localparam int          IW       = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
  localparam logic [12:0] DEPTH_W  = 13'(DEPTH_LINES);
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_e;

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [11:0]  adr_q;
  logic         we_q;
  logic [15:0]  sel_q;
  logic [127:0] wdat_q;
  logic         retry_q;
  logic [127:0] dat_s_q, dat_s_d;
  logic [127:0] mem_q [DEPTH_LINES] = '{default: '0};

  logic         req;
  logic         in_range_i;
  logic         in_range_q;
  logic         retry_hit;
  logic [127:0] rd_line;

  assign req        = wb.cyc & wb.stb;
  assign in_range_i = {1'b0, wb.adr} < DEPTH_W;
  assign in_range_q = {1'b0, adr_q} < DEPTH_W;
  // Out-of-range lines read as zero rather than aliasing onto a real line.
  assign rd_line    = in_range_q ? mem_q[adr_q[IW-1:0]] : '0;

`ifdef WB_LINE_MEM_RETRY_EN
  logic [DEPTH_LINES-1:0] opened_q;
  logic                   rty_q, rty_d;

  assign retry_hit = in_range_i && !opened_q[wb.adr[IW-1:0]];
  // A retried request leaves WAIT after one cycle straight into HOLD.
  assign rty_d     = (state_q == WAIT) && wb.cyc && retry_q;
  assign wb.rty    = rty_q;

  // Remember which lines have already been retried once since reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opened_q <= '0;
      rty_q    <= 1'b0;
    end else begin
      rty_q <= rty_d;
      if (rty_d) opened_q[adr_q[IW-1:0]] <= 1'b1;
    end
  end
`else
  assign retry_hit = 1'b0;
  assign wb.rty    = 1'b0;
`endif

  // State, wait counter, read data and the request captured in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dat_s_q <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      wdat_q  <= '0;
      retry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dat_s_q <= dat_s_d;
      if (state_q == IDLE && req) begin
        adr_q   <= wb.adr;
        we_q    <= wb.we;
        sel_q   <= wb.sel;
        wdat_q  <= wb.dat_m;
        retry_q <= retry_hit;
      end
    end
  end

  // Next state: every request passes through WAIT so ack lands on edge LATENCY,
  // LATENCY=1 included (a single WAIT cycle with the counter already at zero).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      WAIT: begin
        if (!wb.cyc) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (retry_q) begin
          state_d = HOLD;
        end else if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: state_d = HOLD;
      HOLD: begin
        if (!req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: ack is the RESP state; read data is loaded on the edge entering RESP.
  always_comb begin
    dat_s_d = dat_s_q;
    if (state_q == WAIT && wb.cyc && !retry_q && cnt_q == 4'd0 && !we_q) begin
      dat_s_d = rd_line;
    end
  end

  assign wb.ack   = (state_q == RESP);
  assign wb.dat_s = dat_s_q;

  // Byte-masked line write at the edge that ends RESP; contents survive reset.
  always_ff @(posedge clk) begin
    if (state_q == RESP && we_q && in_range_q && !rst) begin
      for (int i = 0; i < 16; i++) begin
        if (sel_q[i]) mem_q[adr_q[IW-1:0]][8*i +: 8] <= wdat_q[8*i +: 8];
      end
    end
  end

endmodule
